key_load_ctrl: RTL and testbench

//   Serial key loader feeding the keyinput bus of a locked (XOR-obfuscated) netlist.
//   - Shifts in KEY_WIDTH key bits plus one even-parity bit from a test/tamper port.
//   - Checks the parity, then presents the key to the downstream obfuscated core.
//   - Holds the key at all-zero until a load succeeds.
//   - Enforces a retry limit, after which it locks out until reset.

---
 rtl/key_load_pkg.sv | 21 ++
 rtl/key_shift_reg.sv | 42 ++++
 rtl/key_load_ctrl.sv | 129 ++++++++++++
 tb/tb_key_load_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/key_load_pkg.sv
// rtl/key_load_pkg.sv - shared types and helpers for the serial key loader
package key_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_ARMED,
    ST_ERR,
    ST_LOCKOUT
  } key_ld_state_t;

  // Key bits plus parity bit must XOR to this value for a load to pass.
  localparam logic PARITY_EVEN = 1'b0;

  // Width of a counter that must hold 0..max_val inclusive.
  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// rtl/key_shift_reg.sv - key shadow register with indexed serial write and running parity
module key_shift_reg
  import key_load_pkg::*;
#(
  parameter int  KEY_WIDTH = 1,
  localparam int CW        = cnt_bits(KEY_WIDTH)
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 clr,
  input  logic                 wr,
  input  logic                 din,
  output logic [KEY_WIDTH-1:0] shadow,
  output logic [CW-1:0]        bit_cnt,
  output logic                 full,
  output logic                 run_par
);

  assign full = (bit_cnt == CW'(KEY_WIDTH));

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      shadow  <= '0;
      bit_cnt <= '0;
      run_par <= 1'b0;
    end else if (clr) begin
      shadow  <= '0;
      bit_cnt <= '0;
      run_par <= 1'b0;
    end else if (wr && !full) begin
      // Decoded write keeps the index in range even when bit_cnt is wider than needed.
      for (int i = 0; i < KEY_WIDTH; i++) begin
        if (bit_cnt == CW'(i)) begin
          shadow[i] <= din;
        end
      end
      bit_cnt <= bit_cnt + CW'(1);
      run_par <= run_par ^ din;
    end
  end

endmodule

// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - serial key loader with parity check, retry limit and lockout
module key_load_ctrl
  import key_load_pkg::*;
#(
  parameter int KEY_WIDTH = 1,
  parameter int MAX_TRIES = 3
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 key_start,
  input  logic                 key_vld,
  input  logic                 key_si,
  output logic [KEY_WIDTH-1:0] keyinput,
  output logic                 key_rdy,
  output logic                 key_err,
  output logic                 lockout
);

  localparam int CW = cnt_bits(KEY_WIDTH);
  localparam int TW = cnt_bits(MAX_TRIES);

  key_ld_state_t          state_q, state_d;
  logic [TW-1:0]          tries_q, tries_d;
  logic                   par_q, par_d;
  logic                   sr_clr, sr_wr, sr_full, sr_par;
  logic [KEY_WIDTH-1:0]   shadow;
  logic [CW-1:0]          bit_cnt;
  logic [KEY_WIDTH-1:0]   key_d;
  logic                   rdy_d, err_d, lock_d;

  key_shift_reg #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_shift (
    .CK     (CK),
    .RN     (RN),
    .clr    (sr_clr),
    .wr     (sr_wr),
    .din    (key_si),
    .shadow (shadow),
    .bit_cnt(bit_cnt),
    .full   (sr_full),
    .run_par(sr_par)
  );

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q  <= ST_IDLE;
      tries_q  <= '0;
      par_q    <= 1'b0;
      keyinput <= '0;
      key_rdy  <= 1'b0;
      key_err  <= 1'b0;
      lockout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      par_q    <= par_d;
      keyinput <= key_d;
      key_rdy  <= rdy_d;
      key_err  <= err_d;
      lockout  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    par_d   = par_q;
    sr_clr  = 1'b0;
    sr_wr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_start) begin
          sr_clr  = 1'b1;
          par_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A restart wins over a data bit arriving in the same cycle.
        if (key_start) begin
          sr_clr = 1'b1;
          par_d  = 1'b0;
        end else if (key_vld) begin
          if (!sr_full) begin
            sr_wr = 1'b1;
          end else begin
            par_d   = key_si;
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if ((sr_par ^ par_q) == PARITY_EVEN) begin
          tries_d = '0;
          state_d = ST_ARMED;
        end else if (int'(tries_q) + 1 < MAX_TRIES) begin
          tries_d = tries_q + TW'(1);
          state_d = ST_ERR;
        end else begin
          tries_d = TW'(MAX_TRIES);
          state_d = ST_LOCKOUT;
        end
      end
      ST_ARMED, ST_ERR: begin
        if (key_start) begin
          sr_clr  = 1'b1;
          par_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_LOCKOUT: begin
        state_d = ST_LOCKOUT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the settled state one edge later, but a key_start drops
    // the armed key on the very edge that samples it.
    rdy_d  = (state_q == ST_ARMED) && !key_start;
    key_d  = rdy_d ? shadow : '0;
    err_d  = (state_q == ST_ERR) && !key_start;
    lock_d = (state_q == ST_LOCKOUT);
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// tb/tb_key_load_ctrl.sv - scoreboard bench for key_load_ctrl at KEY_WIDTH 1 and 8
module tb_key_load_ctrl;

  typedef struct packed {
    logic [7:0] key;
    logic       rdy;
    logic       err;
    logic       lock;
  } exp_t;

  logic       CK = 1'b0;
  logic       RN;
  logic       s1, v1, d1, s8, v8, d8;
  logic [0:0] k1;
  logic [7:0] k8;
  logic       r1, e1, l1, r8, e8, l8;

  int n_pass = 0;
  int n_total = 0;

  exp_t q1[$];
  exp_t q8[$];

  always #5 CK = ~CK;

  key_load_ctrl #(.KEY_WIDTH(1), .MAX_TRIES(3)) u1 (
    .CK(CK), .RN(RN), .key_start(s1), .key_vld(v1), .key_si(d1),
    .keyinput(k1), .key_rdy(r1), .key_err(e1), .lockout(l1)
  );

  key_load_ctrl #(.KEY_WIDTH(8), .MAX_TRIES(3)) u8 (
    .CK(CK), .RN(RN), .key_start(s8), .key_vld(v8), .key_si(d8),
    .keyinput(k8), .key_rdy(r8), .key_err(e8), .lockout(l8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Monitor: each rising response (rdy/err/lockout) retires one scoreboard entry.
  logic pv1 = 1'b0;
  logic pv8 = 1'b0;
  always @(negedge CK) begin : mon
    exp_t e;
    if ((r1 | e1 | l1) && !pv1) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL u1_unexpected: got %b%b%b key %h expected no response", r1, e1, l1, k1);
      end else begin
        e = q1.pop_front();
        chk("u1_resp", {21'd0, 7'd0, k1, r1, e1, l1}, {21'd0, e});
      end
    end
    if ((r8 | e8 | l8) && !pv8) begin
      if (q8.size() == 0) begin
        n_total++;
        $display("FAIL u8_unexpected: got %b%b%b key %h expected no response", r8, e8, l8, k8);
      end else begin
        e = q8.pop_front();
        chk("u8_resp", {21'd0, k8, r8, e8, l8}, {21'd0, e});
      end
    end
    pv1 = r1 | e1 | l1;
    pv8 = r8 | e8 | l8;
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic load1(input logic b, input logic p);
    s1 = 1'b1; tick(); s1 = 1'b0;
    v1 = 1'b1; d1 = b; tick();
    d1 = p; tick();
    v1 = 1'b0; d1 = 1'b0;
  endtask

  task automatic bit8(input logic b, input int gap);
    v8 = 1'b0;
    repeat (gap) tick();
    v8 = 1'b1; d8 = b; tick();
    v8 = 1'b0; d8 = 1'b0;
  endtask

  task automatic shift8(input logic [7:0] k, input logic p);
    for (int i = 0; i < 8; i++) bit8(k[i], 1 + (i % 3));
    bit8(p, 2);
  endtask

  task automatic start8();
    s8 = 1'b1; tick(); s8 = 1'b0;
  endtask

  initial begin : stim
    logic [3:0] g;
    logic s5, s6, s7, g8, g9, g10, g11, g12, g13, g14, g15, g16, g17, ng11;
    RN = 1'b0;
    s1 = 0; v1 = 0; d1 = 0; s8 = 0; v8 = 0; d8 = 0;
    repeat (2) @(posedge CK);
    @(negedge CK);
    chk("rst_u1", {28'd0, k1, r1, e1, l1}, 32'd0);
    chk("rst_u8", {21'd0, k8, r8, e8, l8}, 32'd0);
    tick(); RN = 1'b1;

    // 1: good 1-bit load, two-edge latency after the parity edge
    q1.push_back('{key: 8'h01, rdy: 1'b1, err: 1'b0, lock: 1'b0});
    load1(1'b1, 1'b1);
    @(negedge CK); chk("t1_rdy_e0", {31'd0, r1}, 32'd0);
    tick(); @(negedge CK); chk("t1_rdy_e1", {31'd0, r1}, 32'd0);
    tick(); @(negedge CK); chk("t1_rdy_e2", {31'd0, r1}, 32'd1);
    chk("t1_key", {31'd0, k1}, 32'd1);

    // s27 with an XNOR key gate on G17: correct key makes G17 = ~G11
    s5 = 0; s6 = 0; s7 = 0;
    for (int i = 0; i < 4; i++) begin
      g = 4'($urandom_range(0, 15));
      g14 = ~g[0]; g8 = g14 & s6; g12 = ~(g[1] | s7);
      g15 = g12 | g8; g16 = g[3] | g8; g9 = ~(g16 & g15);
      g11 = ~(s5 | g9); g10 = ~(g14 | g11); g13 = ~(g[2] | g12);
      g17 = ~((~g11) ^ k1[0]);
      ng11 = ~g11;
      chk("s27_g17", {31'd0, g17}, {31'd0, ng11});
      s5 = g10; s6 = g11; s7 = g13;
    end

    // 2: bad parity -> ERR, then a good load re-arms
    q1.push_back('{key: 8'h00, rdy: 1'b0, err: 1'b1, lock: 1'b0});
    load1(1'b1, 1'b0);
    repeat (3) tick();
    chk("t2_err", {31'd0, e1}, 32'd1);
    chk("t2_key0", {31'd0, k1}, 32'd0);
    q1.push_back('{key: 8'h01, rdy: 1'b1, err: 1'b0, lock: 1'b0});
    load1(1'b1, 1'b1);
    repeat (3) tick();

    // 3: three bad loads after a good one -> LOCKOUT on the third
    q1.push_back('{key: 8'h00, rdy: 1'b0, err: 1'b1, lock: 1'b0});
    load1(1'b1, 1'b0); repeat (3) tick();
    q1.push_back('{key: 8'h00, rdy: 1'b0, err: 1'b1, lock: 1'b0});
    load1(1'b0, 1'b1); repeat (3) tick();
    q1.push_back('{key: 8'h00, rdy: 1'b0, err: 1'b0, lock: 1'b1});
    load1(1'b1, 1'b0); repeat (3) tick();
    chk("t3_lock", {30'd0, l1, e1}, 32'd2);
    load1(1'b1, 1'b1); repeat (4) tick();
    chk("t3_ignored", {28'd0, k1, r1, e1, l1}, 32'd1);
    @(posedge CK); #3 RN = 1'b0;
    #1 chk("t3_rn_async", {28'd0, k1, r1, e1, l1}, 32'd0);
    tick(); RN = 1'b1;
    q1.push_back('{key: 8'h01, rdy: 1'b1, err: 1'b0, lock: 1'b0});
    load1(1'b1, 1'b1); repeat (3) tick();

    // 4: 8-bit 0xA5 with valid gaps
    q8.push_back('{key: 8'hA5, rdy: 1'b1, err: 1'b0, lock: 1'b0});
    start8(); shift8(8'hA5, 1'b0);
    repeat (3) tick();
    chk("t4_a5", {24'd0, k8}, 32'hA5);

    // 5: reload clears the key on the sampling edge; restart beats key_vld
    start8();
    @(negedge CK); chk("t5_clear", {23'd0, k8, r8}, 32'd0);
    bit8(1'b1, 1); bit8(1'b0, 2); bit8(1'b1, 3); bit8(1'b1, 1);
    s8 = 1'b1; v8 = 1'b1; d8 = 1'b1; tick();
    s8 = 1'b0; v8 = 1'b0; d8 = 1'b0;
    q8.push_back('{key: 8'h3C, rdy: 1'b1, err: 1'b0, lock: 1'b0});
    shift8(8'h3C, 1'b0);
    repeat (3) tick();
    chk("t5_3c", {24'd0, k8}, 32'h3C);

    // 6: async reset mid-SHIFT, then a fresh load
    start8();
    bit8(1'b1, 1); bit8(1'b1, 1); bit8(1'b0, 1);
    @(posedge CK); #4 RN = 1'b0;
    #1 chk("t6_rn_u8", {21'd0, k8, r8, e8, l8}, 32'd0);
    chk("t6_rn_u1", {28'd0, k1, r1, e1, l1}, 32'd0);
    tick(); RN = 1'b1;
    q8.push_back('{key: 8'h07, rdy: 1'b1, err: 1'b0, lock: 1'b0});
    start8(); shift8(8'h07, 1'b1);
    repeat (3) tick();
    chk("t6_07", {23'd0, k8, r8}, {23'd0, 8'h07, 1'b1});

    repeat (4) tick();
    chk("q1_drained", q1.size(), 32'd0);
    chk("q8_drained", q8.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
